// File: rtl/servo_ramp.sv
// Servo motion sequencer: steps the servo position toward a CPU-set target once every RATE PWM frames.
// Optional ramp-complete interrupt is compiled in when SERVO_RAMP_IRQ_EN is defined.
module servo_ramp #(
  parameter int          BASETIME = 12000000,
  parameter int          MAX_POS  = 10,
  parameter logic [31:0] SRV_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] srv_address_out,
  output logic        srv_sel_out,
  output logic [3:0]  srv_write_mask_out,
  output logic [31:0] srv_write_value_out,
  input  logic        srv_ready_in,
  output logic        done_irq_out
);

  // One servo PWM period, so steps line up with the frames the servo actually outputs.
  localparam int         FRAME     = BASETIME / 1000 * 20 + 2;
  localparam int         FW        = $clog2(FRAME);
  localparam logic [7:0] MAX_POS_B = 8'(MAX_POS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cur_q, cur_d;
  logic [7:0]      tgt_q, tgt_d;
  logic [7:0]      rate_q, rate_d;
  logic            en_q, en_d;
  logic [7:0]      fc_q, fc_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            frame_tick;

  logic            wr_en;
  logic [1:0]      reg_sel;
  logic [7:0]      wdata;
  logic [7:0]      wdata_clamped;
  logic [7:0]      step_val;
  logic            busy;

  logic unused_bits;
  assign unused_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1],
                         write_value_in[31:8]};

  assign wr_en         = sel_in && write_mask_in[0];
  assign reg_sel       = address_in[3:2];
  assign wdata         = write_value_in[7:0];
  assign wdata_clamped = (wdata > MAX_POS_B) ? MAX_POS_B : wdata;

  always_comb begin
    frame_tick = (frame_q == FW'(FRAME - 1));
    frame_d    = frame_tick ? '0 : frame_q + FW'(1);
  end

  assign step_val = (cur_q < tgt_q) ? cur_q + 8'd1 : cur_q - 8'd1;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    fc_d    = fc_q;
    case (state_q)
      ST_IDLE: begin
        if (en_q && cur_q != tgt_q) begin
          if (rate_q == 8'd0) begin
            cur_d   = tgt_q;
            state_d = ST_WRITE;
          end else begin
            fc_d    = 8'd0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Exit check comes first so an abort or retarget onto cur never emits a step.
        if (!en_q || cur_q == tgt_q) begin
          state_d = ST_IDLE;
        end else if (fc_q >= rate_q) begin
          cur_d   = step_val;
          state_d = ST_WRITE;
        end else if (frame_tick) begin
          fc_d = fc_q + 8'd1;
        end
      end
      ST_WRITE: begin
        if (srv_ready_in) begin
          if (cur_q == tgt_q || !en_q) begin
            state_d = ST_IDLE;
          end else begin
            fc_d    = 8'd0;
            state_d = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tgt_d  = tgt_q;
    rate_d = rate_q;
    en_d   = en_q;
    if (wr_en) begin
      case (reg_sel)
        2'd0: tgt_d  = wdata_clamped;
        2'd1: rate_d = wdata;
        2'd3: begin
          en_d = wdata[0];
          // Abort freezes at the position the servo is about to hold, including a same-cycle step.
          if (wdata[1]) tgt_d = cur_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= 8'd0;
      tgt_q   <= 8'd0;
      rate_q  <= 8'd1;
      en_q    <= 1'b0;
      fc_q    <= 8'd0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      en_q    <= en_d;
      fc_q    <= fc_d;
      frame_q <= frame_d;
    end
  end

`ifdef SERVO_RAMP_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (state_q == ST_WRITE) && srv_ready_in && (cur_q == tgt_q);

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign done_irq_out = irq_q;
`else
  assign done_irq_out = 1'b0;
`endif

  assign busy                = (state_q != ST_IDLE);
  assign ready_out           = sel_in;
  assign srv_address_out     = SRV_ADDR;
  assign srv_sel_out         = (state_q == ST_WRITE);
  assign srv_write_mask_out  = srv_sel_out ? 4'b0001 : 4'b0000;
  assign srv_write_value_out = {24'b0, cur_q};

  always_comb begin
    read_value_out = 32'd0;
    if (sel_in && read_in) begin
      case (reg_sel)
        2'd0:    read_value_out = {24'b0, tgt_q};
        2'd1:    read_value_out = {24'b0, rate_q};
        2'd2:    read_value_out = {15'b0, busy, cur_q, tgt_q};
        default: read_value_out = {30'b0, 1'b0, en_q};
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with BASETIME=1000 (22-cycle frames).
module tb_servo_ramp;

  logic        clk;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] srv_address_out;
  logic        srv_sel_out;
  logic [3:0]  srv_write_mask_out;
  logic [31:0] srv_write_value_out;
  logic        srv_ready_in;
  logic        done_irq_out;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int irq_cnt = 0;
  logic [7:0] wr_vals[$];
  int         wr_cyc[$];

  servo_ramp #(.BASETIME(1000), .MAX_POS(10), .SRV_ADDR(32'h0000_0040)) dut (
    .clk(clk), .reset(reset),
    .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out),
    .srv_address_out(srv_address_out), .srv_sel_out(srv_sel_out),
    .srv_write_mask_out(srv_write_mask_out), .srv_write_value_out(srv_write_value_out),
    .srv_ready_in(srv_ready_in), .done_irq_out(done_irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Servo-side monitor: logs each accepted write and its cycle.
  always @(posedge clk) begin
    if (srv_sel_out && srv_ready_in) begin
      wr_vals.push_back(srv_write_value_out[7:0]);
      wr_cyc.push_back(cycle);
      $display("[TB] servo write %0d at cycle %0d", srv_write_value_out[7:0], cycle);
      tests++;
      if (srv_write_mask_out !== 4'b0001) begin
        $display("FAIL srv_mask: got %b expected 0001", srv_write_mask_out);
        fails++;
      end
    end
    if (done_irq_out) irq_cnt++;
    cycle++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] idx, input logic [31:0] v);
    address_in     = {28'd0, idx, 2'b00};
    write_value_in = v;
    write_mask_in  = 4'b0001;
    sel_in         = 1'b1;
    tick();
    sel_in         = 1'b0;
    write_mask_in  = 4'b0000;
    $display("[TB] cpu write reg %0d = 0x%0h", idx, v);
  endtask

  task automatic cpu_read(input logic [1:0] idx, output logic [31:0] v);
    address_in = {28'd0, idx, 2'b00};
    sel_in     = 1'b1;
    read_in    = 1'b1;
    #1;
    v          = read_value_out;
    sel_in     = 1'b0;
    read_in    = 1'b0;
    $display("[TB] cpu read reg %0d = 0x%0h", idx, v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wr_vals.delete();
    wr_cyc.delete();
    irq_cnt = 0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    for (int i = 0; i < budget && wr_vals.size() < n; i++) tick();
    tests++;
    if (wr_vals.size() < n) begin
      $display("FAIL %s timeout: got %0d writes expected %0d", name, wr_vals.size(), n);
      fails++;
    end
  endtask

  task automatic wait_sel(input int budget, input string name);
    for (int i = 0; i < budget && !srv_sel_out; i++) tick();
    tests++;
    if (srv_sel_out !== 1'b1) begin
      $display("FAIL %s sel timeout: got %b expected 1", name, srv_sel_out);
      fails++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    tests++;
    if ({srv_sel_out, srv_write_mask_out, srv_write_value_out, done_irq_out} !== 38'd0) begin
      $display("FAIL reset_outs: got sel=%b mask=%b val=%0h irq=%b expected all 0",
               srv_sel_out, srv_write_mask_out, srv_write_value_out, done_irq_out);
      fails++;
    end
    tests++;
    if (srv_address_out !== 32'h40) begin
      $display("FAIL srv_addr: got %0h expected 40", srv_address_out);
      fails++;
    end
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'd0) begin
      $display("FAIL reset_status: got %0h expected 0", v);
      fails++;
    end
    cpu_read(2'd3, v);
    tests++;
    if (v !== 32'd0) begin
      $display("FAIL reset_control: got %0h expected 0", v);
      fails++;
    end
    cpu_read(2'd1, v);
    tests++;
    if (v !== 32'd1) begin
      $display("FAIL reset_rate: got %0h expected 1", v);
      fails++;
    end
    address_in = 32'd0;
    sel_in = 1'b1;
    #1;
    tests++;
    if (ready_out !== 1'b1) begin
      $display("FAIL ready_out: got %b expected 1", ready_out);
      fails++;
    end
    sel_in = 1'b0;
    srv_ready_in = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    tests++;
    if (wr_vals.size() != 0) begin
      $display("FAIL reset_nowrite: got %0d writes expected 0", wr_vals.size());
      fails++;
    end
  endtask

  task automatic test_ramp_up();
    logic [31:0] v;
    srv_ready_in = 1'b1;
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'd3);
    cpu_write(2'd3, 32'd1);
    wait_writes(3, 200, "ramp");
    if (wr_vals.size() >= 3) begin
      tests++;
      if (wr_vals[0] !== 8'd1 || wr_vals[1] !== 8'd2 || wr_vals[2] !== 8'd3) begin
        $display("FAIL ramp_vals: got %0d,%0d,%0d expected 1,2,3", wr_vals[0], wr_vals[1], wr_vals[2]);
        fails++;
      end
      tests++;
      if (wr_cyc[1] - wr_cyc[0] != 22 || wr_cyc[2] - wr_cyc[1] != 22) begin
        $display("FAIL ramp_spacing: got %0d,%0d expected 22,22",
                 wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
        fails++;
      end
    end
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'h0000_0303) begin
      $display("FAIL ramp_status: got %0h expected 303", v);
      fails++;
    end
    for (int i = 0; i < 60; i++) tick();
    tests++;
    if (wr_vals.size() != 3) begin
      $display("FAIL ramp_count: got %0d expected 3", wr_vals.size());
      fails++;
    end
    tests++;
`ifdef SERVO_RAMP_IRQ_EN
    if (irq_cnt != 1) begin
      $display("FAIL ramp_irq: got %0d pulse-cycles expected 1", irq_cnt);
      fails++;
    end
`else
    if (irq_cnt != 0) begin
      $display("FAIL ramp_irq: got %0d pulse-cycles expected 0", irq_cnt);
      fails++;
    end
`endif
  endtask

  task automatic test_clamp_jump();
    logic [31:0] v;
    do_reset();
    srv_ready_in = 1'b1;
    cpu_write(2'd0, 32'd200);
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'h0000_000A) begin
      $display("FAIL clamp_status: got %0h expected a", v);
      fails++;
    end
    cpu_write(2'd1, 32'd0);
    cpu_write(2'd3, 32'd1);
    wait_writes(1, 50, "jump");
    for (int i = 0; i < 50; i++) tick();
    tests++;
    if (wr_vals.size() != 1 || wr_vals[0] !== 8'd10) begin
      $display("FAIL jump_write: got %0d writes first=%0d expected 1 write of 10",
               wr_vals.size(), (wr_vals.size() > 0) ? wr_vals[0] : 8'd0);
      fails++;
    end
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'h0000_0A0A) begin
      $display("FAIL jump_status: got %0h expected a0a", v);
      fails++;
    end
  endtask

  task automatic test_retarget();
    logic [31:0] v;
    do_reset();
    srv_ready_in = 1'b1;
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'd10);
    cpu_write(2'd3, 32'd1);
    wait_writes(4, 200, "retarget_pre");
    cpu_write(2'd0, 32'd2);
    wait_writes(6, 200, "retarget_post");
    for (int i = 0; i < 60; i++) tick();
    tests++;
    if (wr_vals.size() != 6 || wr_vals[3] !== 8'd4 || wr_vals[4] !== 8'd3 || wr_vals[5] !== 8'd2) begin
      $display("FAIL retarget_seq: got %0d writes expected 6 ending 4,3,2", wr_vals.size());
      fails++;
    end
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'h0000_0202) begin
      $display("FAIL retarget_status: got %0h expected 202", v);
      fails++;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    srv_ready_in = 1'b0;
    cpu_write(2'd1, 32'd0);
    cpu_write(2'd0, 32'd7);
    cpu_write(2'd3, 32'd1);
    wait_sel(20, "bp");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (srv_sel_out !== 1'b1 || srv_write_value_out !== 32'd7 || srv_write_mask_out !== 4'b0001) bad++;
      tick();
    end
    tests++;
    if (bad != 0 || wr_vals.size() != 0) begin
      $display("FAIL bp_hold: got %0d unstable cycles, %0d writes expected 0, 0", bad, wr_vals.size());
      fails++;
    end
    srv_ready_in = 1'b1;
    tick();
    srv_ready_in = 1'b0;
    tests++;
    if (srv_sel_out !== 1'b0) begin
      $display("FAIL bp_drop: got sel=%b expected 0", srv_sel_out);
      fails++;
    end
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (wr_vals.size() != 1 || wr_vals[0] !== 8'd7) begin
      $display("FAIL bp_accept: got %0d writes expected 1 of 7", wr_vals.size());
      fails++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    do_reset();
    srv_ready_in = 1'b1;
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'd10);
    cpu_write(2'd3, 32'd1);
    wait_writes(5, 300, "abort_pre");
    cpu_write(2'd3, 32'd3);
    for (int i = 0; i < 100; i++) tick();
    tests++;
    if (wr_vals.size() != 5) begin
      $display("FAIL abort_count: got %0d writes expected 5", wr_vals.size());
      fails++;
    end
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'h0000_0505) begin
      $display("FAIL abort_status: got %0h expected 505", v);
      fails++;
    end
    cpu_read(2'd3, v);
    tests++;
    if (v !== 32'd1) begin
      $display("FAIL abort_control: got %0h expected 1", v);
      fails++;
    end
    tests++;
    if (irq_cnt != 0) begin
      $display("FAIL abort_irq: got %0d expected 0", irq_cnt);
      fails++;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] v;
    do_reset();
    srv_ready_in = 1'b0;
    cpu_write(2'd1, 32'd0);
    cpu_write(2'd0, 32'd6);
    cpu_write(2'd3, 32'd1);
    wait_sel(20, "rst_mid");
    reset = 1'b1;
    tick();
    tests++;
    if (srv_sel_out !== 1'b0 || srv_write_value_out !== 32'd0) begin
      $display("FAIL rst_mid_sel: got sel=%b val=%0h expected 0,0", srv_sel_out, srv_write_value_out);
      fails++;
    end
    reset = 1'b0;
    tick();
    cpu_read(2'd2, v);
    tests++;
    if (v !== 32'd0) begin
      $display("FAIL rst_mid_status: got %0h expected 0", v);
      fails++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    address_in     = 32'd0;
    sel_in         = 1'b0;
    read_in        = 1'b0;
    write_mask_in  = 4'b0;
    write_value_in = 32'd0;
    srv_ready_in   = 1'b0;
    test_reset();
    test_ramp_up();
    test_clamp_jump();
    test_retarget();
    test_backpressure();
    test_abort();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/servo_ramp.md
# servo_ramp

Memory-mapped motion sequencer that sits between the CPU data bus and the `servo` PWM peripheral. Software writes a target position and a slew rate. The block then steps the servo position by ±1 once every RATE PWM frames, and issues each new position to the servo as a bus write. This gives smooth servo motion without CPU polling, and software can read back ramp progress.

## Interface
- `BASETIME`, default 12000000: clock cycles per second; must equal the downstream servo's value.
- `MAX_POS`, default 10: highest position the servo accepts; larger targets are clamped to it.
- `SRV_ADDR`, default 32'h0: value driven on `srv_address_out`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `address_in`  in  32  CPU bus address; `[3:2]` selects the register.
- `sel_in`  in  1  CPU bus select.
- `read_in`  in  1  CPU read strobe.
- `read_value_out`  out  32  read data, combinational from the registers.
- `write_mask_in`  in  4  byte enables; only bit 0 is used.
- `write_value_in`  in  32  write data.
- `ready_out`  out  1  equals `sel_in` (zero wait state).
- `srv_address_out`  out  32  equals `SRV_ADDR`.
- `srv_sel_out`  out  1  servo bus select; high while a write is pending.
- `srv_write_mask_out`  out  4  4'b0001 while `srv_sel_out` is high, else 0.
- `srv_write_value_out`  out  32  {24'b0, cur}.
- `srv_ready_in`  in  1  servo accept.
- `done_irq_out`  out  1  ramp-complete pulse (see Configuration).

## Operation
- Registers, written when `sel_in && write_mask_in[0]`, using data bits `[7:0]`:
  - 0 TARGET: write sets tgt = min(value, MAX_POS).
  - 1 RATE: frames per step; 0 means jump straight to tgt.
  - 2 STATUS (read-only): {15'b0, busy, cur[7:0], tgt[7:0]}.
  - 3 CONTROL: bit0 = en; bit1 = abort, which sets tgt <= cur and self-clears. Reads return {30'b0, 0, en}.
- Frame counter:
  - Free-running, 0..FRAME-1, where FRAME = BASETIME/1000*20 + 2 (matches the servo PWM period).
  - `frame_tick` is asserted at FRAME-1.
- FSM states: IDLE, WAIT, WRITE.
  - IDLE, busy=0:
    - en && cur≠tgt && RATE≠0 → WAIT; clear frame count fc.
    - en && cur≠tgt && RATE=0 → cur <= tgt, then → WRITE.
  - WAIT:
    - Each `frame_tick` increments fc.
    - When fc reaches RATE: cur <= cur ± 1 toward the current tgt, then → WRITE.
    - en=0, or tgt==cur (after an abort or retarget) → IDLE without a write.
  - WRITE:
    - `srv_sel_out`=1, with value and mask stable, until `srv_ready_in` is sampled high.
    - On that edge: cur==tgt || !en → IDLE; otherwise → WAIT with fc cleared.
- busy = (state≠IDLE).
- Retarget:
  - A TARGET write in WAIT takes effect at the next step; direction is recomputed.
  - A TARGET write in WRITE does not disturb the in-flight write.
- CPU writes and servo handshakes are independent; both can occur in the same cycle. The CPU register update is visible the following cycle.
- A CPU write to TARGET in the same cycle as the WAIT step decision: the step uses the old tgt.

## Timing
- Reset values:
  - State IDLE; cur=0, tgt=0, RATE=1, en=0, frame counter 0.
  - `srv_sel_out`=0, `srv_write_mask_out`=0, `srv_write_value_out`=0, `done_irq_out`=0.
  - cur=0 matches the servo's reset selector, so no write is issued at reset.
- Reset mid-WRITE: `srv_sel_out` is low in the cycle after reset is sampled.
- Step latency from WAIT entry: between RATE-1 and RATE frames, because the first frame is partial.
- Handshake:
  - At most one write is in flight.
  - `srv_sel_out` drops in the cycle after the accept.
  - `srv_sel_out` stays low for at least one cycle between writes.
- IDLE→WAIT/WRITE: one cycle after the register write that makes cur≠tgt.

## Configuration
- `SERVO_RAMP_IRQ_EN` defined:
  - `done_irq_out` pulses high for exactly one cycle on the WRITE→IDLE transition where cur==tgt.
  - No pulse on an abort or an en=0 exit.
- Macro undefined: `done_irq_out` is tied to 0, and no IRQ logic is compiled in.

## Test plan
- Reset → all outputs 0; STATUS read = 0; CONTROL read = 0; no servo write for 100 cycles.
- Ramp up, with BASETIME=1000 (FRAME=22), RATE=1, en=1, TARGET=3, `srv_ready_in`=1:
  - Servo writes 1, 2, 3, spaced 22 cycles apart.
  - busy drops after the write of 3.
  - With the macro, one `done_irq_out` pulse.
- Clamp and jump:
  - TARGET=200 → STATUS tgt field = 10.
  - RATE=0 from cur=0 → a single servo write of value 10.
- Retarget: ramp 0→10 at RATE=1; write TARGET=2 when cur=4 → the following writes are 3, then 2; then IDLE.
- Backpressure: hold `srv_ready_in`=0 for 5 cycles during a write → `srv_sel_out`, value and mask are held stable; exactly one accept.
- Abort and reset:
  - Abort at cur=5 while in WAIT → IDLE, no further writes, tgt=5, no IRQ.
  - Reset asserted mid-WRITE → `srv_sel_out`=0 next cycle, cur=0.
